ray_reciprocal: RTL
===================

Name: ray_reciprocal

Overview:
- Requester-side client of the fixed-point divider core (nd/rfd/rdy handshake).
- Accepts a 3-component ray direction vector and issues DIVIDEND/d for x, y and z in turn, one at a time, through the divider.
- Collects the three signed Q4.32 reciprocals and presents them as one vector to the octree traversal stage.
- Handles zero components locally and recovers from a divider that never answers.

Parameters:
- DIVIDEND, 1, 4-bit unsigned numerator driven on div_dividend.
- TIMEOUT, 64, cycles to wait for div_rdy after issue before abandoning a component.
- SAT_VAL, 36'h7_FFFF_FFFF, substitute result for a zero component or a timed-out component.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  direction vector valid.
- in_ready  out  1  block idle, can accept a vector.
- dir_x  in  32  signed divisor, x.
- dir_y  in  32  signed divisor, y.
- dir_z  in  32  signed divisor, z.
- out_valid  out  1  result vector valid.
- out_ready  in  1  downstream accepts result.
- inv_x  out  36  signed Q4.32 reciprocal, x.
- inv_y  out  36  signed Q4.32 reciprocal, y.
- inv_z  out  36  signed Q4.32 reciprocal, z.
- zero_flags  out  3  bit i set when component i was zero ({z,y,x}).
- timeout_flags  out  3  bit i set when component i timed out.
- div_nd  out  1  new-data strobe to divider.
- div_rfd  in  1  divider ready for data.
- div_rdy  in  1  divider result strobe, one cycle wide.
- div_dividend  out  4  numerator to divider.
- div_divisor  out  32  divisor to divider.
- div_quotient  in  4  integer part of result.
- div_fractional  in  32  fractional part of result.

Behaviour:
- Reset (async, rst_n low):
  - State forces IDLE.
  - in_ready=1; out_valid=0; div_nd=0.
  - div_divisor=0; div_dividend=DIVIDEND.
  - inv_* = 0; both flag vectors = 0.
  - Timeout counter = 0; component index = 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture dir_x/y/z into registers, clear flags, set index=0, go to ISSUE. in_ready drops the next cycle.
- ISSUE, selected component == 0:
  - Do not assert div_nd.
  - Write SAT_VAL to the result and set zero_flags[i].
  - Advance the index; after the last component go to DONE. Costs one cycle.
- ISSUE, selected component != 0:
  - Drive div_divisor with the component.
  - Assert div_nd for exactly one cycle, in a cycle where div_rfd=1. If div_rfd=0, wait with div_nd=0.
  - Then go to WAIT with the counter cleared.
- div_divisor and div_dividend hold steady from the nd cycle until rdy is seen or a timeout occurs.
- WAIT:
  - On div_rdy: result = {div_quotient, div_fractional}, used as-is with no sign fix-up, because the divider already returns a signed truncate-toward-zero value of DIVIDEND·2^32/d.
  - Then advance to the next component, or to DONE after z.
  - The counter increments each cycle. When it reaches TIMEOUT without div_rdy: result = SAT_VAL, set timeout_flags[i], advance.
  - div_rdy and the timeout firing in the same cycle: div_rdy wins.
- DONE:
  - out_valid=1; inv_* and flags stable.
  - On out_ready: out_valid drops and the block goes to IDLE. in_ready=1 the following cycle, so at most one vector is in flight.
- div_rdy arriving in IDLE, ISSUE or DONE (late answer after a timeout, or after reset) is ignored.
- in_valid outside IDLE is ignored; the upstream must hold in_valid until in_ready.
- Latency with a divider answering 11 cycles after nd: in_valid to out_valid ≈ 3×(1+11+1)+2 cycles. Zero components shorten it.
- Result width: 36 bits. Overflow (|d|<DIVIDEND/8) wraps exactly as the divider returns it and is not flagged.

Decomposition:
- Shared raycaster package holds:
  - state enum;
  - Q4.32 width constant (36);
  - divisor width (32);
  - default SAT_VAL.
- No sub-module. A behavioral divider model is instantiated only in the bench.

Test Plan:
- dir=(2,1,-4), DIVIDEND=1, divider model answering 11 cycles after nd -> inv_x=36'h0_8000_0000, inv_y=36'h1_0000_0000, inv_z=36'hF_C000_0000, flags 0, three nd pulses.
- dir=(0,2,0) -> inv_x=inv_z=SAT_VAL, zero_flags=3'b101, exactly one div_nd pulse, inv_y=36'h0_8000_0000.
- Divider holds div_rfd=0 for 20 cycles -> div_nd stays low until div_rfd=1, then pulses exactly once, results correct.
- Divider never asserts div_rdy for y -> after 64 WAIT cycles inv_y=SAT_VAL, timeout_flags=3'b010; a late div_rdy injected afterwards does not change any output.
- out_ready low for 10 cycles in DONE -> out_valid, inv_* and flags stable; in_ready=0; a second in_valid is not captured.
- rst_n pulled low mid-WAIT -> outputs at reset values immediately; a subsequent div_rdy is ignored; the next vector after release completes correctly.

Source files
------------

// File: rtl/ray_reciprocal_pkg.sv
// Shared raycaster definitions for the reciprocal stage.
//   state_e          : control states of the ray_reciprocal sequencer
//   Q_W              : width of a signed Q4.32 reciprocal
//   DIV_W            : width of a signed direction component / divisor
//   NUM_COMP         : components per direction vector (x, y, z)
//   LAST_IDX         : index of the final component (z)
//   SAT_VAL_DEFAULT  : substitute result for zero or abandoned components
package ray_reciprocal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int Q_W      = 36;
  localparam int DIV_W    = 32;
  localparam int NUM_COMP = 3;

  localparam logic [1:0]     LAST_IDX        = 2'd2;
  localparam logic [Q_W-1:0] SAT_VAL_DEFAULT = 36'h7_FFFF_FFFF;

endpackage

// File: rtl/ray_reciprocal.sv
// Reciprocal stage for ray directions. Takes one direction vector, sends
// DIVIDEND/d for x, y, z one at a time through the external divider core
// (nd/rfd/rdy handshake) and presents the three Q4.32 reciprocals together.
// Zero components never reach the divider; a divider that stays silent for
// TIMEOUT cycles is abandoned for that component.
//
// Handshakes:
//   in_valid/in_ready   : a vector is taken on a rising edge where both are 1;
//                         in_ready is 1 only while idle.
//   out_valid/out_ready : the result is consumed on a rising edge where both
//                         are 1; out_valid then drops and in_ready rises.
//   div_nd/div_rfd      : div_nd is only ever high in a cycle where div_rfd=1,
//                         and for one cycle per issued component.
//   div_rdy             : one-cycle result strobe, only honoured in WAIT.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid, in_ready         vector input handshake
//   dir_x, dir_y, dir_z        signed 32-bit direction components
//   out_valid, out_ready       result handshake
//   inv_x, inv_y, inv_z        signed Q4.32 reciprocals
//   zero_flags                 {z,y,x}: component was zero
//   timeout_flags              {z,y,x}: divider never answered
//   div_nd, div_rfd, div_rdy   divider handshake
//   div_dividend, div_divisor  divider operands
//   div_quotient, div_fractional  divider result (integer, fraction)
module ray_reciprocal
  import ray_reciprocal_pkg::*;
#(
  parameter logic [3:0]     DIVIDEND = 4'd1,
  parameter int             TIMEOUT  = 64,
  parameter logic [Q_W-1:0] SAT_VAL  = SAT_VAL_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIV_W-1:0] dir_x,
  input  logic [DIV_W-1:0] dir_y,
  input  logic [DIV_W-1:0] dir_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q_W-1:0]   inv_x,
  output logic [Q_W-1:0]   inv_y,
  output logic [Q_W-1:0]   inv_z,
  output logic [2:0]       zero_flags,
  output logic [2:0]       timeout_flags,
  output logic             div_nd,
  input  logic             div_rfd,
  input  logic             div_rdy,
  output logic [3:0]       div_dividend,
  output logic [DIV_W-1:0] div_divisor,
  input  logic [3:0]       div_quotient,
  input  logic [31:0]      div_fractional
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e                           state_q, state_d;
  logic [NUM_COMP-1:0][DIV_W-1:0]   dir_q, dir_d;
  logic [NUM_COMP-1:0][Q_W-1:0]     inv_q, inv_d;
  logic [1:0]                       idx_q, idx_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [2:0]                       zero_flags_q, zero_flags_d;
  logic [2:0]                       timeout_flags_q, timeout_flags_d;
  logic [DIV_W-1:0]                 div_divisor_q, div_divisor_d;
  logic                             in_ready_q, in_ready_d;
  logic                             out_valid_q, out_valid_d;
  logic                             advance;
  logic                             comp_nz;

  // div_divisor_q is loaded with the selected component whenever ISSUE is
  // entered, so in ISSUE it doubles as "the current component".
  assign comp_nz = (div_divisor_q != '0);

  // The strobe is qualified by div_rfd in the same cycle so that it can
  // never land in a cycle where the divider is not ready; the state moves
  // to WAIT on that same edge, which bounds it to one cycle.
  assign div_nd = (state_q == ST_ISSUE) && comp_nz && div_rfd;

  assign div_dividend  = DIVIDEND;
  assign div_divisor   = div_divisor_q;
  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign inv_x         = inv_q[0];
  assign inv_y         = inv_q[1];
  assign inv_z         = inv_q[2];
  assign zero_flags    = zero_flags_q;
  assign timeout_flags = timeout_flags_q;

  always_comb begin
    state_d         = state_q;
    dir_d           = dir_q;
    inv_d           = inv_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q;
    zero_flags_d    = zero_flags_q;
    timeout_flags_d = timeout_flags_q;
    div_divisor_d   = div_divisor_q;
    in_ready_d      = in_ready_q;
    out_valid_d     = out_valid_q;
    advance         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dir_d           = {dir_z, dir_y, dir_x};
          zero_flags_d    = '0;
          timeout_flags_d = '0;
          idx_d           = '0;
          div_divisor_d   = dir_x;
          in_ready_d      = 1'b0;
          state_d         = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (!comp_nz) begin
          // Zero component: answered locally, divider untouched.
          inv_d[idx_q]        = SAT_VAL;
          zero_flags_d[idx_q] = 1'b1;
          advance             = 1'b1;
        end else if (div_rfd) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (div_rdy) begin
          // Divider already returns a signed truncated quotient.
          inv_d[idx_q] = {div_quotient, div_fractional};
          advance      = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          inv_d[idx_q]           = SAT_VAL;
          timeout_flags_d[idx_q] = 1'b1;
          advance                = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (advance) begin
      if (idx_q == LAST_IDX) begin
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end else begin
        idx_d         = idx_q + 2'd1;
        div_divisor_d = dir_q[idx_q + 2'd1];
        state_d       = ST_ISSUE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      dir_q           <= '0;
      inv_q           <= '0;
      idx_q           <= '0;
      cnt_q           <= '0;
      zero_flags_q    <= '0;
      timeout_flags_q <= '0;
      div_divisor_q   <= '0;
      in_ready_q      <= 1'b1;
      out_valid_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      dir_q           <= dir_d;
      inv_q           <= inv_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      zero_flags_q    <= zero_flags_d;
      timeout_flags_q <= timeout_flags_d;
      div_divisor_q   <= div_divisor_d;
      in_ready_q      <= in_ready_d;
      out_valid_q     <= out_valid_d;
    end
  end

endmodule
